// File: rtl/gate_eval_pkg.sv
// Shared types and constants for the gate evaluation arbiter.
// Holds the FSM state encoding, default sizing and the index-width helper.
package gate_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_LAT   = 2;
  localparam int CNT_W     = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nand_xor_unit.sv
// Shared combinational evaluation unit: f1 = NAND(a, b), f2 = f1 XOR c.
module nand_xor_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f1,
  output logic f2
);

  assign f1 = ~(a & b);
  assign f2 = f1 ^ c;

endmodule

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one NAND/XOR unit
// whose result appears LAT cycles after the grant.
module gate_eval_arbiter
  import gate_eval_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int LAT   = DEF_LAT,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a_in,
  input  logic [N_REQ-1:0] b_in,
  input  logic [N_REQ-1:0] c_in,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] done_id,
  output logic             f1_out,
  output logic             f2_out
);

  localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LAT - 1);
  localparam logic [IDX_W-1:0] LAST_ID = IDX_W'(N_REQ - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur_id;
  logic [CNT_W-1:0] cnt;
  logic             cap_a;
  logic             cap_b;
  logic             cap_c;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic             f1;
  logic             f2;

  // Winner search: walk downward so the candidate closest to ptr is written last.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand    = IDX_W'((int'(ptr) + i) % N_REQ);
      win_idx = req[cand] ? cand : win_idx;
      any_req = any_req | req[cand];
    end
  end

  nand_xor_unit u_eval (
    .a  (cap_a),
    .b  (cap_b),
    .c  (cap_c),
    .f1 (f1),
    .f2 (f2)
  );

  // Arbitration FSM with registered grant, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur_id  <= '0;
      cnt     <= '0;
      cap_a   <= 1'b0;
      cap_b   <= 1'b0;
      cap_c   <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      f1_out  <= 1'b0;
      f2_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (any_req) begin
            state  <= EVAL;
            gnt    <= GNT_ONE << win_idx;
            busy   <= 1'b1;
            cur_id <= win_idx;
            cap_a  <= a_in[win_idx];
            cap_b  <= b_in[win_idx];
            cap_c  <= c_in[win_idx];
            cnt    <= '0;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        EVAL: begin
          gnt <= '0;
          if (cnt == LAT_M1) begin
            state   <= DONE;
            done    <= 1'b1;
            f1_out  <= f1;
            f2_out  <= f2;
            done_id <= cur_id;
            ptr     <= (cur_id == LAST_ID) ? '0 : cur_id + IDX_W'(1);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench: a LAT=2 instance for arbitration/abort and a LAT=1 instance
// for the short-latency path, both with four requesters.
module tb_gate_eval_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req0, a0, b0, c0, gnt0;
  logic       busy0, done0, f10, f20;
  logic [1:0] id0;
  logic [3:0] req1, a1, b1, c1, gnt1;
  logic       busy1, done1, f11, f21;
  logic [1:0] id1;

  int n_checks = 0;
  int n_fail   = 0;

  gate_eval_arbiter #(.N_REQ(4), .LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .a_in(a0), .b_in(b0), .c_in(c0),
    .gnt(gnt0), .busy(busy0), .done(done0), .done_id(id0),
    .f1_out(f10), .f2_out(f20)
  );

  gate_eval_arbiter #(.N_REQ(4), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .a_in(a1), .b_in(b1), .c_in(c1),
    .gnt(gnt1), .busy(busy1), .done(done1), .done_id(id1),
    .f1_out(f11), .f2_out(f21)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 4'b0000; a0 = 4'b0000; b0 = 4'b0000; c0 = 4'b0000;
    req1 = 4'b0000; a1 = 4'b0000; b1 = 4'b0000; c1 = 4'b0000;
    tick(2);
    check("rst_gnt", 32'(gnt0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_id", 32'(id0), 32'h0);
    check("rst_f1", 32'(f10), 32'h0);
    check("rst_f2", 32'(f20), 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("rel_busy", 32'(busy0), 32'h0);
    check("rel_gnt", 32'(gnt0), 32'h0);

    // single request: NAND(1,1)=0, 0^0=0
    req0 = 4'b0001; a0 = 4'b0001; b0 = 4'b0001; c0 = 4'b0000;
    tick(1);
    check("s1_gnt", 32'(gnt0), 32'h1);
    check("s1_busy", 32'(busy0), 32'h1);
    req0 = 4'b0000;
    tick(1);
    check("s1_gnt_pulse", 32'(gnt0), 32'h0);
    check("s1_nodone_early", 32'(done0), 32'h0);
    tick(1);
    check("s1_done", 32'(done0), 32'h1);
    check("s1_id", 32'(id0), 32'h0);
    check("s1_f1", 32'(f10), 32'h0);
    check("s1_f2", 32'(f20), 32'h0);
    check("s1_busy_done", 32'(busy0), 32'h1);
    tick(1);
    check("s1_done_pulse", 32'(done0), 32'h0);
    check("s1_idle_busy", 32'(busy0), 32'h0);

    // repeat: NAND(0,1)=1, 1^1=0
    req0 = 4'b0001; a0 = 4'b0000; b0 = 4'b0001; c0 = 4'b0001;
    tick(1);
    check("s2_gnt", 32'(gnt0), 32'h1);
    req0 = 4'b0000;
    tick(2);
    check("s2_done", 32'(done0), 32'h1);
    check("s2_f1", 32'(f10), 32'h1);
    check("s2_f2", 32'(f20), 32'h0);
    tick(2);
    check("s2_hold_f1", 32'(f10), 32'h1);

    // round robin from a fresh ptr=0
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    req0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      tick(1);
      check($sformatf("rr_gnt%0d", k), 32'(gnt0), 32'(exp_g));
      if (k < 4) begin
        tick(3);
        check($sformatf("rr_gap%0d", k), 32'(gnt0), 32'h0);
      end else begin
        req0 = 4'b0000;
      end
    end
    tick(3);

    // rotation: requester 2 wins (ptr 1), then 0101 -> 0 then 2
    req0 = 4'b0100;
    tick(1);
    check("rot_g2", 32'(gnt0), 32'h4);
    req0 = 4'b0101;
    tick(4);
    check("rot_g0", 32'(gnt0), 32'h1);
    req0 = 4'b0100;
    tick(4);
    check("rot_g2b", 32'(gnt0), 32'h4);
    req0 = 4'b0000;
    tick(3);

    // abort during EVAL of requester 1
    req0 = 4'b0010;
    tick(1);
    check("ab_gnt", 32'(gnt0), 32'h2);
    req0 = 4'b0000;
    tick(1);
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(busy0), 32'h0);
    check("ab_done", 32'(done0), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("ab_no_done", 32'(done0), 32'h0);
    req0 = 4'b0110;
    tick(1);
    check("ab_regnt", 32'(gnt0), 32'h2);
    req0 = 4'b0000;
    tick(3);

    // LAT=1: NAND(1,0)=1, 1^1=0; live operands change after grant
    req1 = 4'b1000; a1 = 4'b1000; b1 = 4'b0000; c1 = 4'b1000;
    tick(1);
    check("l1_gnt", 32'(gnt1), 32'h8);
    req1 = 4'b0000; a1 = 4'b1000; b1 = 4'b1000; c1 = 4'b0000;
    tick(1);
    check("l1_done", 32'(done1), 32'h1);
    check("l1_id", 32'(id1), 32'h3);
    check("l1_f1", 32'(f11), 32'h1);
    check("l1_f2", 32'(f21), 32'h0);
    tick(1);
    check("l1_done_pulse", 32'(done1), 32'h0);
    check("l1_hold_id", 32'(id1), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
